// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Classifies a debounced button level into short press, long press and
//   double click, and emits one-cycle event pulses for the RGB mode/colour
//   controller. The design is a registered FSM with a single shared cycle
//   counter, and every output is a flop.
//
//   Optional feature: define REPEAT_EN to enable auto-repeat while the button
//   is held after a long press (repeat_pulse every REPEAT_CYCLES). When
//   REPEAT_EN is undefined, repeat_pulse stays 0 and the counter is held at 0
//   in HOLD.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   btn_in        debounced button level, 1 = pressed
//   short_press   1-cycle pulse: single press released, no 2nd press in window
//   long_press    1-cycle pulse: press held LONG_PRESS_CYCLES
//   double_click  1-cycle pulse: 2nd press started inside the window
//   repeat_pulse  1-cycle pulse: auto-repeat while held
//   btn_held      level: 1 while in HOLD
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES    = 50_000_000,
  parameter int DCLICK_WINDOW_CYCLES = 15_000_000,
  parameter int REPEAT_CYCLES        = 10_000_000,
  parameter int CNT_W                = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic btn_held
);

  // Catch parameter sets that would let the counter miss its terminal count.
  if (LONG_PRESS_CYCLES < 2 || DCLICK_WINDOW_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_min
    $error("button_event_decoder: *_CYCLES must be >= 2");
  end
  if (longint'(LONG_PRESS_CYCLES) > (64'd1 << CNT_W) ||
      longint'(DCLICK_WINDOW_CYCLES) > (64'd1 << CNT_W) ||
      longint'(REPEAT_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_width
    $error("button_event_decoder: CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_WINDOW_CYCLES - 1);
`ifdef REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, HOLD, WAITREL} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             short_n, long_n, dclick_n, rep_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      // WAITREL: a button held through reset is ignored until released.
      state        <= WAITREL;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      repeat_pulse <= 1'b0;
      btn_held     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_click <= dclick_n;
      repeat_pulse <= rep_n;
      btn_held     <= (state_n == HOLD);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    dclick_n = 1'b0;
    rep_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (btn_in) state_n = PRESS1;
      end
      PRESS1: begin
        // Release is checked first so it wins over the terminal count.
        if (!btn_in) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_TC) begin
          state_n = HOLD;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        // A second press wins over the window expiring on the same edge.
        if (btn_in) begin
          state_n  = WAITREL;
          cnt_n    = '0;
          dclick_n = 1'b1;
        end else if (cnt == DCLICK_TC) begin
          state_n = IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        cnt_n = '0;
        if (!btn_in) begin
          state_n = IDLE;
        end
`ifdef REPEAT_EN
        else if (cnt == REPEAT_TC) begin
          rep_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      WAITREL: begin
        cnt_n = '0;
        if (!btn_in) state_n = IDLE;
      end
      default: begin
        state_n = WAITREL;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder (LONG=20, WINDOW=8, REPEAT=5).
// Expected events (edge number + event code) are queued as stimulus is driven;
// a negedge monitor pops and compares every pulse the DUT produces.
module tb_button_event_decoder;

  localparam int LONG = 20;
  localparam int WIN  = 8;
  localparam int REP  = 5;

  localparam logic [3:0] EV_SHORT = 4'b0001;
  localparam logic [3:0] EV_LONG  = 4'b0010;
  localparam logic [3:0] EV_DCLK  = 4'b0100;
  localparam logic [3:0] EV_REP   = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic short_press, long_press, double_click, repeat_pulse, btn_held;

  button_event_decoder #(
    .LONG_PRESS_CYCLES   (LONG),
    .DCLICK_WINDOW_CYCLES(WIN),
    .REPEAT_CYCLES       (REP),
    .CNT_W               (26)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .repeat_pulse(repeat_pulse),
    .btn_held    (btn_held)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         at;
    logic [3:0] ev;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] ev);
    sb.push_back('{at, ev});
  endtask

  // Drive v for n rising edges; returns #1 after the last of them.
  task automatic drive(input logic v, input int n);
    btn_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the events for a hold of n edges starting at edge e0.
  task automatic expect_hold(input int e0, input int n);
    if (n > LONG) expect_ev(e0 + LONG, EV_LONG);
`ifdef REPEAT_EN
    for (int t = e0 + LONG + REP; t <= e0 + n - 1; t += REP) expect_ev(t, EV_REP);
`endif
  endtask

  // Release, let any pending timer run out, then all queued events must be seen.
  task automatic drain(input string tag);
    drive(1'b0, WIN + 4);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  logic [3:0] mon_ev;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_ev = {repeat_pulse, double_click, long_press, short_press};
    if (mon_ev != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", mon_ev, 4'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_cycle", cyc, mon_e.at);
        chk("event_kind", mon_ev, mon_e.ev);
      end
    end
  end

  int e0;

  initial begin
    // Reset state
    reset = 1'b1;
    drive(1'b0, 3);
    chk("reset_outputs", {27'b0, repeat_pulse, double_click, long_press, short_press, btn_held}, 0);
    reset = 1'b0;
    drive(1'b0, 2);

    // 1: short press, pulse WIN edges after the release edge
    drive(1'b1, 5);
    expect_ev(cyc + 1 + WIN, EV_SHORT);
    drain("t1_short");

    // 2: double click on the edge sampling the 2nd press
    drive(1'b1, 5);
    drive(1'b0, 3);
    expect_ev(cyc + 1, EV_DCLK);
    drive(1'b1, 4);
    drain("t2_dclick");

    // 3: long press, btn_held, no short on release
    e0 = cyc + 1;
    expect_hold(e0, 30);
    drive(1'b1, 10);
    chk("t3_held_early", btn_held, 0);
    drive(1'b1, 20);
    chk("t3_held", btn_held, 1);
    drive(1'b0, 1);
    chk("t3_held_release", btn_held, 0);
    drain("t3_long");

    // 4a: release on the PRESS1 terminal edge -> short, not long
    drive(1'b1, LONG);
    expect_ev(cyc + 1 + WIN, EV_SHORT);
    drain("t4_release_wins");

    // 4b: 2nd press on the GAP terminal edge -> double click only
    drive(1'b1, 5);
    drive(1'b0, WIN);
    expect_ev(cyc + 1, EV_DCLK);
    drive(1'b1, 3);
    drain("t4_press_wins");

    // 5a: held through reset is ignored until released
    reset  = 1'b1;
    drive(1'b1, 2);
    chk("t5_reset_outputs", {27'b0, repeat_pulse, double_click, long_press, short_press, btn_held}, 0);
    reset = 1'b0;
    drive(1'b1, 10);
    drain("t5_held_thru_reset");

    // 5b: reset in the middle of GAP aborts the short press
    drive(1'b1, 3);
    drive(1'b0, 4);
    reset = 1'b1;
    drive(1'b0, 2);
    reset = 1'b0;
    drain("t5_reset_gap");

    // 5c: reset in HOLD drops btn_held
    e0 = cyc + 1;
    expect_hold(e0, 25);
    drive(1'b1, 25);
    chk("t5_held_before_reset", btn_held, 1);
    reset = 1'b1;
    drive(1'b1, 1);
    chk("t5_held_after_reset", btn_held, 0);
    reset = 1'b0;
    drive(1'b1, 3);
    drain("t5_reset_hold");

    // 6: long hold; with REPEAT_EN four repeat pulses, otherwise none
    e0 = cyc + 1;
    expect_hold(e0, 41);
    drive(1'b1, 41);
    drain("t6_repeat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
